// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC owner: single-outstanding imem handshake, valid/ready output slot, redirect flush.
// Optional MISALIGN_TRAP_EN: misaligned redirect targets raise misaligned_o and park the unit in TRAP.
module pc_fetch_unit #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       PCSrc,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [XLEN-1:0]  ALUResultE,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic [XLEN-1:0]  instr_pc_o,
  output logic             flush_o,
  output logic             misaligned_o
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [2:0] {ST_BOOT, ST_FETCH, ST_WAIT, ST_DROP, ST_TRAP} state_t;
`else
  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_WAIT, ST_DROP} state_t;
`endif

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [XLEN-1:0]  ipc_q, ipc_d;

  logic             redirect_code;
  logic             redirect;
  logic             consume;
  logic             req;
  logic             issue;
  logic             outstanding;
  logic [XLEN-1:0]  target_raw;
  logic [XLEN-1:0]  target;

`ifdef MISALIGN_TRAP_EN
  logic             mis_q, mis_d;
  logic             target_mis;
`endif

  always_comb begin
    redirect_code = (PCSrc == 2'b01) || (PCSrc == 2'b10);
    consume       = valid_q && instr_ready_i;
    // Space rule: only ask for a new word when the output slot will be free to receive it.
    req           = (state_q == ST_FETCH) && (!valid_q || instr_ready_i);
    issue         = req && imem_gnt;
    target_raw    = (PCSrc == 2'b10) ? (ALUResultE & ~XLEN'(1)) : PCTargetE;
`ifdef MISALIGN_TRAP_EN
    target        = target_raw;
    target_mis    = (target_raw[1:0] != 2'b00);
    redirect      = redirect_code && (state_q != ST_BOOT) && (state_q != ST_TRAP);
`else
    target        = target_raw & ~XLEN'(3);
    redirect      = redirect_code && (state_q != ST_BOOT);
`endif
    outstanding   = (((state_q == ST_WAIT) || (state_q == ST_DROP)) && !imem_rvalid) ||
                    ((state_q == ST_FETCH) && issue);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
`ifdef MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    if (redirect) begin
      // Redirect beats consume/refill; a request still in flight must be drained in DROP.
      pc_d    = target;
      valid_d = 1'b0;
      state_d = outstanding ? ST_DROP : ST_FETCH;
`ifdef MISALIGN_TRAP_EN
      if (target_mis) begin
        mis_d   = 1'b1;
        state_d = ST_TRAP;
      end
`endif
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_FETCH;
        ST_FETCH: begin
          if (consume) valid_d = 1'b0;
          if (issue)   state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + XLEN'(4);
            state_d = ST_FETCH;
          end else if (consume) begin
            valid_d = 1'b0;
          end
        end
        ST_DROP: begin
          if (consume)     valid_d = 1'b0;
          if (imem_rvalid) state_d = ST_FETCH;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign imem_req      = req;
  assign imem_addr     = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = valid_q ? instr_q : NOP_INSTR;
  assign instr_pc_o    = ipc_q;
  assign flush_o       = redirect_code;
`ifdef MISALIGN_TRAP_EN
  assign misaligned_o  = mis_q;
`else
  assign misaligned_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: a flag-based reference model of the fetch contract
// plus a one-request instruction memory that answers with a word derived from the address.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] PCTargetE = '0;
  logic [31:0] ALUResultE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        flush_o;
  logic        misaligned_o;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: PC, output slot, whether a request is in flight and whether it is stale.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_busy;
  logic        m_dead;
  logic        m_boot;
  logic        m_trap;
  logic        m_mis;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .flush_o(flush_o), .misaligned_o(misaligned_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance the model at the rising edge.
  task automatic applyStimulus(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                               input logic gnt, input logic wantRv, input logic rdy);
    logic        expReq, redirect, issue, rv;
    logic [31:0] t;
    PCSrc         = src;
    PCTargetE     = tgt;
    ALUResultE    = alu;
    imem_gnt      = gnt;
    instr_ready_i = rdy;
    rv            = wantRv && m_busy;
    imem_rvalid   = rv;
    imem_rdata    = rv ? memWord(m_pc) : $urandom;
    expReq        = !m_boot && !m_trap && !m_busy && (!m_valid || rdy);
    #1;
    checkOutput("imem_req", 32'(imem_req), 32'(expReq));
    if (expReq) checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("flush_o", 32'(flush_o), 32'((src == 2'b01) || (src == 2'b10)));
    checkOutput("instr_valid_o", 32'(instr_valid_o), 32'(m_valid));
    checkOutput("instr_o", instr_o, m_valid ? m_instr : NOP);
    if (m_valid) checkOutput("instr_pc_o", instr_pc_o, m_ipc);
    checkOutput("misaligned_o", 32'(misaligned_o), 32'(m_mis));
    @(posedge clk);
    redirect = ((src == 2'b01) || (src == 2'b10)) && !m_boot && !m_trap;
    issue    = expReq && gnt;
    t        = (src == 2'b10) ? (alu & ~32'd1) : tgt;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_trap) begin
      if (redirect) begin
        m_valid = 1'b0;
        m_dead  = (m_busy && !rv) || issue;
`ifdef MISALIGN_TRAP_EN
        m_pc = t;
        if (t[1:0] != 2'b00) begin
          m_trap = 1'b1;
          m_mis  = 1'b1;
        end
`else
        m_pc = t & ~32'd3;
`endif
      end else begin
        if (rv && !m_dead) begin
          m_valid = 1'b1;
          m_instr = memWord(m_pc);
          m_ipc   = m_pc;
          m_pc    = m_pc + 32'd4;
        end else if (m_valid && rdy) begin
          m_valid = 1'b0;
        end
        if (issue) m_dead = 1'b0;
      end
    end
    if (rv)    m_busy = 1'b0;
    if (issue) m_busy = 1'b1;
    @(negedge clk);
  endtask

  task automatic doReset();
    #2;
    rst_n       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid_o), 32'd0);
    checkOutput("rst_instr_o", instr_o, NOP);
    checkOutput("rst_instr_pc_o", instr_pc_o, 32'd0);
    checkOutput("rst_misaligned_o", 32'(misaligned_o), 32'd0);
    m_pc = 32'd0; m_valid = 1'b0; m_instr = NOP; m_ipc = 32'd0;
    m_busy = 1'b0; m_dead = 1'b0; m_boot = 1'b1; m_trap = 1'b0; m_mis = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic randomCycles(input int n);
    logic [1:0]  src;
    logic [31:0] tgt, alu;
    for (int i = 0; i < n; i++) begin
      src = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
      tgt = $urandom;
      alu = $urandom;
`ifdef MISALIGN_TRAP_EN
      tgt = tgt & ~32'd3;
      alu = alu & ~32'd2;
`endif
      applyStimulus(src, tgt, alu, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    logic reached;
    @(negedge clk);
    doReset();

    // Boot latency and sequential stream until a request for 0x10 is waiting.
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (m_busy && m_pc == 32'h10) reached = 1'b1;
      else applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 1'b1);
    end
    checkOutput("reach_wait_0x10", 32'(reached), 32'd1);

    // Branch redirect while waiting: late response must be discarded.
    applyStimulus(2'b01, 32'h100, '0, 1'b1, 1'b0, 1'b1);
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 1'b1);
    applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 1'b1);
    repeat (4) applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 1'b1);

    // Decode stall then release.
    repeat (6) applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 1'b1);

    // PC wrap at the top of the address space.
    applyStimulus(2'b01, 32'hFFFF_FFFC, '0, 1'b0, 1'b1, 1'b1);
    repeat (8) applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 1'b1);

    randomCycles(1500);

    // JALR redirect coinciding with a response.
    for (int i = 0; i < 20 && !m_busy; i++) applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("reach_busy_t4", 32'(m_busy), 32'd1);
    applyStimulus(2'b10, '0, 32'h205, 1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 1'b1);
`ifdef MISALIGN_TRAP_EN
    applyStimulus(2'b01, 32'h102, '0, 1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus(2'b01, 32'h200, '0, 1'b1, 1'b1, 1'b1);
`endif

    // Reset while a request is outstanding.
    for (int i = 0; i < 20 && !m_busy; i++) applyStimulus(2'b00, '0, '0, 1'b1, 1'b0, 1'b1);
    doReset();
    repeat (6) applyStimulus(2'b00, '0, '0, 1'b1, 1'b1, 1'b1);

    randomCycles(500);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
